rf_writeback: RTL and testbench

Write-back stage for the RV32IMACZicsr core, sitting on the write side of `reg_file`. It arbitrates results from the ALU, load/store unit (LSU) and multiply/divide unit (MDU) onto the single register-file write port. It holds a one-cycle registered write stage. It also keeps a busy scoreboard of destination registers that have outstanding long-latency (LSU/MDU) writes, which the issue stage queries.

---
 rtl/rf_writeback_if.sv | 53 +++++
 rtl/rf_writeback.sv | 136 +++++++++++++
 tb/tb_rf_writeback.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_writeback_if.sv
// Signal bundle between the execution units / issue stage and rf_writeback.
// master drives results and queries; slave is the write-back stage.
interface rf_writeback_if #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned REG_AW = 5
);
   logic              alu_valid_in;
   logic [REG_AW-1:0] alu_rd_in;
   logic [XLEN-1:0]   alu_data_in;
   logic              lsu_valid_in;
   logic [REG_AW-1:0] lsu_rd_in;
   logic [XLEN-1:0]   lsu_data_in;
   logic              lsu_ready_out;
   logic              mdu_valid_in;
   logic [REG_AW-1:0] mdu_rd_in;
   logic [XLEN-1:0]   mdu_data_in;
   logic              mdu_ready_out;
   logic              issue_valid_in;
   logic [REG_AW-1:0] issue_rd_in;
   logic [REG_AW-1:0] rs1_address_in;
   logic [REG_AW-1:0] rs2_address_in;
   logic              rs1_busy_out;
   logic              rs2_busy_out;
   logic              rs1_fwd_valid_out;
   logic              rs2_fwd_valid_out;
   logic [XLEN-1:0]   rs1_fwd_data_out;
   logic [XLEN-1:0]   rs2_fwd_data_out;
   logic [REG_AW-1:0] destination_register_out;
   logic [XLEN-1:0]   write_data_out;
   logic              wb_valid_out;

   modport master (
      output alu_valid_in, alu_rd_in, alu_data_in,
      output lsu_valid_in, lsu_rd_in, lsu_data_in,
      output mdu_valid_in, mdu_rd_in, mdu_data_in,
      output issue_valid_in, issue_rd_in, rs1_address_in, rs2_address_in,
      input  lsu_ready_out, mdu_ready_out,
      input  rs1_busy_out, rs2_busy_out, rs1_fwd_valid_out, rs2_fwd_valid_out,
      input  rs1_fwd_data_out, rs2_fwd_data_out,
      input  destination_register_out, write_data_out, wb_valid_out
   );

   modport slave (
      input  alu_valid_in, alu_rd_in, alu_data_in,
      input  lsu_valid_in, lsu_rd_in, lsu_data_in,
      input  mdu_valid_in, mdu_rd_in, mdu_data_in,
      input  issue_valid_in, issue_rd_in, rs1_address_in, rs2_address_in,
      output lsu_ready_out, mdu_ready_out,
      output rs1_busy_out, rs2_busy_out, rs1_fwd_valid_out, rs2_fwd_valid_out,
      output rs1_fwd_data_out, rs2_fwd_data_out,
      output destination_register_out, write_data_out, wb_valid_out
   );
endinterface

// File: rtl/rf_writeback.sv
// Register-file write-back stage: ALU-priority / LSU-MDU round-robin arbitration, one registered
// write stage and a busy scoreboard. Define RF_WB_FWD_EN for early busy clear plus forwarding.
module rf_writeback #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned REG_AW = 5
) (
   input logic           clk_in,
   input logic           reset_in,
   rf_writeback_if.slave wb_if
);
   localparam int unsigned NumRegs = 1 << REG_AW;

   typedef enum logic {PtrLsu = 1'b0, PtrMdu = 1'b1} ptr_e;

   ptr_e               ptr_q, ptr_d;
   logic [NumRegs-1:0] busy_q, busy_d;
   logic               wb_valid_q, wb_valid_d;
   logic [REG_AW-1:0]  wb_rd_q, wb_rd_d;
   logic [XLEN-1:0]    wb_data_q, wb_data_d;
`ifndef RF_WB_FWD_EN
   logic               wb_ll_q, wb_ll_d;
`endif

   logic              lsu_gnt, mdu_gnt, any_gnt;
   logic [REG_AW-1:0] gnt_rd;
   logic [XLEN-1:0]   gnt_data;

   // Nothing is accepted while reset is held, so the ready outputs stay low.
   always_comb begin
      lsu_gnt = 1'b0;
      mdu_gnt = 1'b0;
      if (!wb_if.alu_valid_in && !reset_in) begin
         if (wb_if.lsu_valid_in && wb_if.mdu_valid_in) begin
            lsu_gnt = (ptr_q == PtrLsu);
            mdu_gnt = (ptr_q == PtrMdu);
         end else begin
            lsu_gnt = wb_if.lsu_valid_in;
            mdu_gnt = wb_if.mdu_valid_in;
         end
      end
   end

   always_comb begin
      any_gnt  = wb_if.alu_valid_in | lsu_gnt | mdu_gnt;
      gnt_rd   = '0;
      gnt_data = '0;
      if (wb_if.alu_valid_in) begin
         gnt_rd   = wb_if.alu_rd_in;
         gnt_data = wb_if.alu_data_in;
      end else if (lsu_gnt) begin
         gnt_rd   = wb_if.lsu_rd_in;
         gnt_data = wb_if.lsu_data_in;
      end else if (mdu_gnt) begin
         gnt_rd   = wb_if.mdu_rd_in;
         gnt_data = wb_if.mdu_data_in;
      end

      ptr_d = ptr_q;
      if (lsu_gnt) begin
         ptr_d = PtrMdu;
      end else if (mdu_gnt) begin
         ptr_d = PtrLsu;
      end

      // reg_file writes every cycle, so an idle stage must present rd=0.
      wb_valid_d = any_gnt && (gnt_rd != '0);
      wb_rd_d    = wb_valid_d ? gnt_rd : '0;
      wb_data_d  = wb_valid_d ? gnt_data : '0;
`ifndef RF_WB_FWD_EN
      wb_ll_d    = wb_valid_d && (lsu_gnt || mdu_gnt);
`endif
   end

   // Clear first so that a same-edge set of the same register wins.
   always_comb begin
      busy_d = busy_q;
`ifdef RF_WB_FWD_EN
      if (lsu_gnt || mdu_gnt) begin
         busy_d[gnt_rd] = 1'b0;
      end
`else
      if (wb_ll_q) begin
         busy_d[wb_rd_q] = 1'b0;
      end
`endif
      if (wb_if.issue_valid_in && (wb_if.issue_rd_in != '0)) begin
         busy_d[wb_if.issue_rd_in] = 1'b1;
      end
   end

   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         ptr_q      <= PtrLsu;
         busy_q     <= '0;
         wb_valid_q <= 1'b0;
         wb_rd_q    <= '0;
         wb_data_q  <= '0;
`ifndef RF_WB_FWD_EN
         wb_ll_q    <= 1'b0;
`endif
      end else begin
         ptr_q      <= ptr_d;
         busy_q     <= busy_d;
         wb_valid_q <= wb_valid_d;
         wb_rd_q    <= wb_rd_d;
         wb_data_q  <= wb_data_d;
`ifndef RF_WB_FWD_EN
         wb_ll_q    <= wb_ll_d;
`endif
      end
   end

   assign wb_if.lsu_ready_out            = lsu_gnt;
   assign wb_if.mdu_ready_out            = mdu_gnt;
   assign wb_if.wb_valid_out             = wb_valid_q;
   assign wb_if.destination_register_out = wb_rd_q;
   assign wb_if.write_data_out           = wb_data_q;
   // busy[0] is never set, so address 0 reads as not busy.
   assign wb_if.rs1_busy_out             = busy_q[wb_if.rs1_address_in];
   assign wb_if.rs2_busy_out             = busy_q[wb_if.rs2_address_in];

`ifdef RF_WB_FWD_EN
   logic rs1_hit, rs2_hit;
   assign rs1_hit = wb_valid_q && (wb_rd_q == wb_if.rs1_address_in) && (wb_if.rs1_address_in != '0);
   assign rs2_hit = wb_valid_q && (wb_rd_q == wb_if.rs2_address_in) && (wb_if.rs2_address_in != '0);
   assign wb_if.rs1_fwd_valid_out = rs1_hit;
   assign wb_if.rs2_fwd_valid_out = rs2_hit;
   assign wb_if.rs1_fwd_data_out  = rs1_hit ? wb_data_q : '0;
   assign wb_if.rs2_fwd_data_out  = rs2_hit ? wb_data_q : '0;
`else
   assign wb_if.rs1_fwd_valid_out = 1'b0;
   assign wb_if.rs2_fwd_valid_out = 1'b0;
   assign wb_if.rs1_fwd_data_out  = '0;
   assign wb_if.rs2_fwd_data_out  = '0;
`endif
endmodule

// File: tb/tb_rf_writeback.sv
// Scoreboard bench for rf_writeback: directed scenarios plus random traffic checked against a
// cycle-level model of the arbitration, write stage and busy scoreboard.
module tb_rf_writeback;
   localparam int XLEN   = 32;
   localparam int REG_AW = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   rf_writeback_if #(.XLEN(XLEN), .REG_AW(REG_AW)) bus ();
   rf_writeback #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (.clk_in(clk), .reset_in(rst), .wb_if(bus));

   typedef struct {
      logic        v;
      logic [4:0]  rd;
      logic [31:0] d;
   } wr_t;

   typedef struct packed {
      logic        av;
      logic [4:0]  ar;
      logic [31:0] ad;
      logic        lv;
      logic [4:0]  lr;
      logic [31:0] ld;
      logic        mv;
      logic [4:0]  mr;
      logic [31:0] md;
      logic        iv;
      logic [4:0]  ir;
      logic [4:0]  q1;
      logic [4:0]  q2;
   } stim_t;

   wr_t         exp_q[$];
   int          checks   = 0;
   int          failures = 0;
   // Model state: architectural busy set, round-robin preference, pending late clear, staged write.
   logic [31:0] exp_busy = '0;
   bit          pref_mdu = 1'b0;
   bit          clr_pend = 1'b0;
   logic [4:0]  clr_rd   = '0;
   wr_t         last_wr  = '{1'b0, 5'd0, 32'd0};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_q(input string nm, input logic [4:0] a, input logic b, input logic fv,
                        input logic [31:0] fd);
      logic        efv;
      logic [31:0] efd;
      chk({nm, "_busy"}, {31'd0, b}, {31'd0, exp_busy[a]});
`ifdef RF_WB_FWD_EN
      efv = last_wr.v && (last_wr.rd == a) && (a != 5'd0);
      efd = efv ? last_wr.d : 32'd0;
`else
      efv = 1'b0;
      efd = 32'd0;
`endif
      chk({nm, "_fwd_valid"}, {31'd0, fv}, {31'd0, efv});
      chk({nm, "_fwd_data"}, fd, efd);
   endtask

   task automatic model_reset();
      exp_q.delete();
      exp_busy = '0;
      pref_mdu = 1'b0;
      clr_pend = 1'b0;
      clr_rd   = '0;
      last_wr  = '{1'b0, 5'd0, 32'd0};
   endtask

   task automatic drive_idle();
      bus.alu_valid_in   = 1'b0; bus.alu_rd_in = '0; bus.alu_data_in = '0;
      bus.lsu_valid_in   = 1'b0; bus.lsu_rd_in = '0; bus.lsu_data_in = '0;
      bus.mdu_valid_in   = 1'b0; bus.mdu_rd_in = '0; bus.mdu_data_in = '0;
      bus.issue_valid_in = 1'b0; bus.issue_rd_in = '0;
      bus.rs1_address_in = '0;   bus.rs2_address_in = '0;
   endtask

   // Apply one cycle of stimulus (called at a negedge), check the pre-edge combinational
   // outputs, push the expected staged write and advance the model across the edge.
   task automatic step(input stim_t s, output bit lg, output bit mg);
      wr_t         w;
      logic [31:0] nb;
      bus.alu_valid_in   = s.av; bus.alu_rd_in = s.ar; bus.alu_data_in = s.ad;
      bus.lsu_valid_in   = s.lv; bus.lsu_rd_in = s.lr; bus.lsu_data_in = s.ld;
      bus.mdu_valid_in   = s.mv; bus.mdu_rd_in = s.mr; bus.mdu_data_in = s.md;
      bus.issue_valid_in = s.iv; bus.issue_rd_in = s.ir;
      bus.rs1_address_in = s.q1; bus.rs2_address_in = s.q2;
      #1;
      lg = 1'b0;
      mg = 1'b0;
      if (!s.av) begin
         if (s.lv && s.mv) begin
            if (pref_mdu) mg = 1'b1;
            else lg = 1'b1;
         end else begin
            lg = s.lv;
            mg = s.mv;
         end
      end
      chk("lsu_ready", {31'd0, bus.lsu_ready_out}, {31'd0, lg});
      chk("mdu_ready", {31'd0, bus.mdu_ready_out}, {31'd0, mg});
      chk_q("rs1", s.q1, bus.rs1_busy_out, bus.rs1_fwd_valid_out, bus.rs1_fwd_data_out);
      chk_q("rs2", s.q2, bus.rs2_busy_out, bus.rs2_fwd_valid_out, bus.rs2_fwd_data_out);

      w = '{1'b0, 5'd0, 32'd0};
      if (s.av) begin
         if (s.ar != 5'd0) w = '{1'b1, s.ar, s.ad};
      end else if (lg) begin
         if (s.lr != 5'd0) w = '{1'b1, s.lr, s.ld};
      end else if (mg) begin
         if (s.mr != 5'd0) w = '{1'b1, s.mr, s.md};
      end
      exp_q.push_back(w);

      if (lg) pref_mdu = 1'b1;
      if (mg) pref_mdu = 1'b0;
      nb = exp_busy;
`ifdef RF_WB_FWD_EN
      if (lg) nb[s.lr] = 1'b0;
      if (mg) nb[s.mr] = 1'b0;
`else
      if (clr_pend) nb[clr_rd] = 1'b0;
      clr_pend = lg || mg;
      clr_rd   = lg ? s.lr : s.mr;
`endif
      if (s.iv && (s.ir != 5'd0)) nb[s.ir] = 1'b1;
      nb[0]    = 1'b0;
      exp_busy = nb;
      last_wr  = w;
      @(posedge clk);
      @(negedge clk);
   endtask

   // Monitor: compare the staged write after every active edge outside reset.
   always @(posedge clk) begin
      wr_t e;
      #1;
      if (!rst) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL wb_queue actual=empty required=entry @%0t", $time);
         end else begin
            e = exp_q.pop_front();
            chk("wb_valid", {31'd0, bus.wb_valid_out}, {31'd0, e.v});
            chk("wb_rd", {27'd0, bus.destination_register_out}, {27'd0, e.rd});
            chk("wb_data", bus.write_data_out, e.d);
         end
      end
   end

   initial begin
      stim_t       s;
      bit          lg, mg;
      bit          lp, mp;
      logic [4:0]  lr, mr;
      logic [31:0] ld, md;

      drive_idle();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      // Reset state, with results presented that must not be accepted.
      bus.lsu_valid_in = 1'b1; bus.lsu_rd_in = 5'd4;
      bus.mdu_valid_in = 1'b1; bus.mdu_rd_in = 5'd6;
      bus.rs1_address_in = 5'd4;
      #1;
      chk("rst_lsu_ready", {31'd0, bus.lsu_ready_out}, 32'd0);
      chk("rst_mdu_ready", {31'd0, bus.mdu_ready_out}, 32'd0);
      chk("rst_wb_valid", {31'd0, bus.wb_valid_out}, 32'd0);
      chk("rst_wb_rd", {27'd0, bus.destination_register_out}, 32'd0);
      chk("rst_wb_data", bus.write_data_out, 32'd0);
      chk("rst_busy", {31'd0, bus.rs1_busy_out}, 32'd0);
      @(negedge clk);
      drive_idle();
      model_reset();
      rst = 1'b0;

      // Round-robin from the reset pointer; ungranted results are held.
      lr = 5'd10; ld = 32'h1000_0000; mr = 5'd20; md = 32'h2000_0000;
      for (int i = 0; i < 4; i++) begin
         s = '0;
         s.lv = 1'b1; s.lr = lr; s.ld = ld;
         s.mv = 1'b1; s.mr = mr; s.md = md;
         step(s, lg, mg);
         chk("rr_lsu_turn", {31'd0, lg}, {31'd0, ((i % 2) == 0)});
         if (lg) ld = ld + 32'd1;
         if (mg) md = md + 32'd1;
      end

      // ALU priority over a waiting LSU result.
      s = '0;
      s.av = 1'b1; s.ar = 5'd3; s.ad = 32'h11;
      s.lv = 1'b1; s.lr = 5'd4; s.ld = 32'h22;
      step(s, lg, mg);
      chk("prio_rd_alu", {27'd0, bus.destination_register_out}, 32'd3);
      chk("prio_data_alu", bus.write_data_out, 32'h11);
      s.av = 1'b0;
      step(s, lg, mg);
      chk("prio_rd_lsu", {27'd0, bus.destination_register_out}, 32'd4);
      chk("prio_data_lsu", bus.write_data_out, 32'h22);

      // MDU result to x0 is accepted but produces no write.
      s = '0;
      s.mv = 1'b1; s.mr = 5'd0; s.md = 32'hDEAD;
      step(s, lg, mg);
      chk("rd0_valid", {31'd0, bus.wb_valid_out}, 32'd0);
      chk("rd0_data", bus.write_data_out, 32'd0);

      // Scoreboard on rd=9: issue, LSU accept at edge k, observe cycles k+1 and k+2.
      s = '0; s.iv = 1'b1; s.ir = 5'd9; s.q1 = 5'd9;
      step(s, lg, mg);
      chk("sb_busy_set", {31'd0, bus.rs1_busy_out}, 32'd1);
      s = '0; s.lv = 1'b1; s.lr = 5'd9; s.ld = 32'hCAFE_0009; s.q1 = 5'd9;
      step(s, lg, mg);
`ifdef RF_WB_FWD_EN
      chk("sb_busy_k1", {31'd0, bus.rs1_busy_out}, 32'd0);
      chk("sb_fwd_valid_k1", {31'd0, bus.rs1_fwd_valid_out}, 32'd1);
      chk("sb_fwd_data_k1", bus.rs1_fwd_data_out, 32'hCAFE_0009);
`else
      chk("sb_busy_k1", {31'd0, bus.rs1_busy_out}, 32'd1);
      chk("sb_fwd_valid_k1", {31'd0, bus.rs1_fwd_valid_out}, 32'd0);
`endif
      s = '0; s.q1 = 5'd9;
      step(s, lg, mg);
      chk("sb_busy_k2", {31'd0, bus.rs1_busy_out}, 32'd0);

      // Set wins over clear: issue rd=9 on both the accept edge and the following edge.
      s = '0; s.iv = 1'b1; s.ir = 5'd9; s.q1 = 5'd9;
      step(s, lg, mg);
      s.lv = 1'b1; s.lr = 5'd9; s.ld = 32'h0000_0909;
      step(s, lg, mg);
      s.lv = 1'b0;
      step(s, lg, mg);
      chk("sb_set_wins", {31'd0, bus.rs1_busy_out}, 32'd1);
      s = '0; s.lv = 1'b1; s.lr = 5'd9; s.ld = 32'h0000_0990; s.q1 = 5'd9;
      step(s, lg, mg);
      s = '0; s.q1 = 5'd9;
      step(s, lg, mg);

      // Reset mid-stream with a live staged write and busy[7].
      s = '0; s.iv = 1'b1; s.ir = 5'd7; s.q1 = 5'd7;
      step(s, lg, mg);
      s = '0; s.av = 1'b1; s.ar = 5'd5; s.ad = 32'h55; s.q1 = 5'd7;
      step(s, lg, mg);
      chk("pre_rst_valid", {31'd0, bus.wb_valid_out}, 32'd1);
      chk("pre_rst_busy7", {31'd0, bus.rs1_busy_out}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", {31'd0, bus.wb_valid_out}, 32'd0);
      chk("mid_rst_rd", {27'd0, bus.destination_register_out}, 32'd0);
      chk("mid_rst_data", bus.write_data_out, 32'd0);
      chk("mid_rst_busy7", {31'd0, bus.rs1_busy_out}, 32'd0);
      repeat (2) @(negedge clk);
      drive_idle();
      model_reset();
      rst = 1'b0;
      s = '0; s.iv = 1'b1; s.ir = 5'd7; s.q1 = 5'd7;
      step(s, lg, mg);
      s = '0; s.lv = 1'b1; s.lr = 5'd7; s.ld = 32'h7777_0007; s.q1 = 5'd7;
      step(s, lg, mg);
      s = '0; s.q1 = 5'd7;
      step(s, lg, mg);
      step(s, lg, mg);

      // Random traffic; LSU/MDU results are held until accepted.
      lp = 1'b0; mp = 1'b0;
      lr = '0; mr = '0; ld = '0; md = '0;
      for (int i = 0; i < 600; i++) begin
         if (!lp && ($urandom_range(0, 1) == 0)) begin
            lp = 1'b1; lr = 5'($urandom_range(0, 7)); ld = $urandom;
         end
         if (!mp && ($urandom_range(0, 1) == 0)) begin
            mp = 1'b1; mr = 5'($urandom_range(0, 7)); md = $urandom;
         end
         s = '0;
         s.av = ($urandom_range(0, 2) == 0);
         s.ar = 5'($urandom_range(0, 7));
         s.ad = $urandom;
         s.lv = lp; s.lr = lr; s.ld = ld;
         s.mv = mp; s.mr = mr; s.md = md;
         s.iv = ($urandom_range(0, 3) == 0);
         s.ir = 5'($urandom_range(0, 7));
         s.q1 = 5'($urandom_range(0, 7));
         s.q2 = (last_wr.v && ($urandom_range(0, 1) == 0)) ? last_wr.rd
                                                            : 5'($urandom_range(0, 7));
         step(s, lg, mg);
         if (lg) lp = 1'b0;
         if (mg) mp = 1'b0;
      end

      s = '0;
      repeat (3) step(s, lg, mg);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
